hdmi_data_out: RTL

Display-side counterpart to the HDMI capture path. It generates VESA raster timing on the pixel clock and requests RGB565 pixels from the frame-buffer read FIFO one cycle ahead of need. Each pixel is expanded to RGB888 and driven with aligned HS/VS/DE to the HDMI transmitter. A read underflow is flagged and the affected pixel is output as black, so sync timing is never disturbed.

---
 rtl/hdmi_data_out.sv | 135 +++++++++++++
 1 files changed

// File: rtl/hdmi_data_out.sv
// VESA raster generator and RGB565-to-RGB888 pixel output stage for the HDMI transmitter.
// Pixels are requested one slot ahead; an empty FIFO yields a black pixel and a sticky flag.
module hdmi_data_out #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 110,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 220,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned V_FP     = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 20,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1
) (
  input  logic        hdmi_pix_clk,
  input  logic        rst,
  input  logic        en,
  output logic        rd_req,
  input  logic [15:0] rd_data,
  input  logic        rd_empty,
  output logic        frame_start,
  output logic        hs_out,
  output logic        vs_out,
  output logic        de_out,
  output logic [7:0]  red_out,
  output logic [7:0]  green_out,
  output logic [7:0]  blue_out,
  output logic        underflow
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW     = $clog2(HTotal);
  localparam int unsigned VW     = $clog2(VTotal);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e          state_q, state_d;
  logic [HW-1:0]   h_cnt_q, h_cnt_d;
  logic [VW-1:0]   v_cnt_q, v_cnt_d;
  logic [31:0]     h_ext, v_ext;
  logic            running, h_last, v_last;
  logic            act0, hs0, vs0;

  // Stage 1 holds the slot decoded in the request cycle, stage 2 drives the pins.
  logic            de1_q, hs1_q, vs1_q, bad1_q;
  logic            de_out_q, hs_out_q, vs_out_q, hs_out_d, vs_out_d;
  logic [23:0]     rgb_q, rgb_d;
  logic            underflow_q, underflow_d;

  assign h_ext   = 32'(h_cnt_q);
  assign v_ext   = 32'(v_cnt_q);
  assign running = (state_q != StIdle);
  assign h_last  = (h_ext == HTotal - 1);
  assign v_last  = (v_ext == VTotal - 1);

  assign act0 = running && (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);
  assign hs0  = running && (h_ext >= H_ACTIVE + H_FP) && (h_ext < H_ACTIVE + H_FP + H_SYNC);
  assign vs0  = running && (v_ext >= V_ACTIVE + V_FP) && (v_ext < V_ACTIVE + V_FP + V_SYNC);

  assign rd_req      = act0 & ~rd_empty;
  assign frame_start = running && (h_cnt_q == '0) && (v_cnt_q == '0);

  always_comb begin
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (running) begin
      if (h_last) begin
        h_cnt_d = '0;
        v_cnt_d = v_last ? '0 : v_cnt_q + VW'(1);
      end else begin
        h_cnt_d = h_cnt_q + HW'(1);
      end
    end
    case (state_q)
      StIdle:  if (en) state_d = StRun;
      StRun:   if (!en) state_d = StDrain;
      // en is ignored here so the frame in flight always completes.
      StDrain: if (h_last && v_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rgb_d = '0;
    if (de1_q && !bad1_q) begin
      rgb_d = {rd_data[15:11], rd_data[15:13],
               rd_data[10:5],  rd_data[10:9],
               rd_data[4:0],   rd_data[4:2]};
    end
    hs_out_d    = hs1_q ? HS_POL : ~HS_POL;
    vs_out_d    = vs1_q ? VS_POL : ~VS_POL;
    underflow_d = underflow_q | (act0 & rd_empty);
  end

  always_ff @(posedge hdmi_pix_clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      de1_q       <= 1'b0;
      hs1_q       <= 1'b0;
      vs1_q       <= 1'b0;
      bad1_q      <= 1'b0;
      de_out_q    <= 1'b0;
      hs_out_q    <= ~HS_POL;
      vs_out_q    <= ~VS_POL;
      rgb_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      de1_q       <= act0;
      hs1_q       <= hs0;
      vs1_q       <= vs0;
      bad1_q      <= act0 & rd_empty;
      de_out_q    <= de1_q;
      hs_out_q    <= hs_out_d;
      vs_out_q    <= vs_out_d;
      rgb_q       <= rgb_d;
      underflow_q <= underflow_d;
    end
  end

  assign de_out    = de_out_q;
  assign hs_out    = hs_out_q;
  assign vs_out    = vs_out_q;
  assign red_out   = rgb_q[23:16];
  assign green_out = rgb_q[15:8];
  assign blue_out  = rgb_q[7:0];
  assign underflow = underflow_q;

endmodule
